branch_resolve_unit: RTL and testbench

- Parametrised successor of the single-cycle branch comparator in the EX stage.
- Registers a signed/unsigned compare of two operands under an extended 3-bit condition code. Produces a one-cycle-latency taken/mispredict result for the pipeline control.
- Keeps a direct-mapped table of 2-bit saturating counters that supplies a taken prediction to IF.

---
 rtl/branch_resolve_unit_pkg.sv | 28 ++
 rtl/branch_predictor_table.sv | 33 +++
 rtl/branch_resolve_unit.sv | 106 ++++++++++
 tb/tb_branch_resolve_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: condition codes and predictor counter helpers.
package branch_resolve_unit_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_LT   = 3'b001;
  localparam logic [2:0] BR_EQ   = 3'b010;
  localparam logic [2:0] BR_GT   = 3'b011;
  localparam logic [2:0] BR_NE   = 3'b100;
  localparam logic [2:0] BR_LTU  = 3'b101;
  localparam logic [2:0] BR_GTU  = 3'b110;
  localparam logic [2:0] BR_GE   = 3'b111;

  // Weakly not-taken.
  localparam logic [1:0] CTR_INIT = 2'b01;

  // Saturating 2-bit counter step.
  function automatic logic [1:0] ctrNext(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// Direct-mapped table of 2-bit saturating counters with one update port and one
// combinational lookup port; lookup sees the pre-update value.
module branch_predictor_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned IDX_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                updEn,
  input  logic [IDX_BITS-1:0] updIdx,
  input  logic                updTaken,
  input  logic [IDX_BITS-1:0] lookupIdx,
  output logic                lookupTaken
);

  localparam int unsigned Depth = 2 ** IDX_BITS;

  logic [1:0] ctrQ [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        ctrQ[i] <= CTR_INIT;
      end
    end else if (updEn) begin
      ctrQ[updIdx] <= ctrNext(ctrQ[updIdx], updTaken);
    end
  end

  assign lookupTaken = ctrQ[lookupIdx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: registered signed/unsigned compare with mispredict flag,
// plus a counter-based taken predictor feeding IF.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IDX_BITS = 3,
  parameter int unsigned PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic [2:0]          branch_op,
  input  logic [WIDTH-1:0]    reg_a,
  input  logic [WIDTH-1:0]    reg_b,
  input  logic [PC_WIDTH-1:0] br_pc,
  input  logic                pred_in,
  input  logic [PC_WIDTH-1:0] pred_pc,
  output logic                pred_taken,
  output logic                out_valid,
  output logic                jmp_true,
  output logic                mispredict,
  output logic [WIDTH-1:0]    result
);

  logic [WIDTH:0] diff;
  logic           borrow;
  logic           overflow;
  logic           ltSigned;
  logic           isEq;
  logic           taken;

  assign diff     = {1'b0, reg_a} - {1'b0, reg_b};
  assign borrow   = diff[WIDTH];
  assign isEq     = (reg_a == reg_b);
  // Overflow when operand signs differ and the result sign disagrees with reg_a.
  assign overflow = (reg_a[WIDTH-1] != reg_b[WIDTH-1]) && (diff[WIDTH-1] != reg_a[WIDTH-1]);
  assign ltSigned = diff[WIDTH-1] ^ overflow;

  always_comb begin
    taken = 1'b0;
    case (branch_op)
      BR_NONE: taken = 1'b0;
      BR_LT:   taken = ltSigned;
      BR_EQ:   taken = isEq;
      BR_GT:   taken = !ltSigned && !isEq;
      BR_NE:   taken = !isEq;
      BR_LTU:  taken = borrow;
      BR_GTU:  taken = !borrow && !isEq;
      BR_GE:   taken = !ltSigned;
      default: taken = 1'b0;
    endcase
  end

  logic             outValidQ;
  logic             jmpTrueQ;
  logic             mispredictQ;
  logic [WIDTH-1:0] resultQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValidQ   <= 1'b0;
      jmpTrueQ    <= 1'b0;
      mispredictQ <= 1'b0;
      resultQ     <= '0;
    end else if (!stall) begin
      if (flush || !in_valid) begin
        outValidQ   <= 1'b0;
        jmpTrueQ    <= 1'b0;
        mispredictQ <= 1'b0;
      end else begin
        outValidQ   <= 1'b1;
        jmpTrueQ    <= taken;
        mispredictQ <= taken ^ pred_in;
        resultQ     <= diff[WIDTH-1:0];
      end
    end
  end

  assign out_valid  = outValidQ;
  assign jmp_true   = jmpTrueQ;
  assign mispredict = mispredictQ;
  assign result     = resultQ;

  logic updEn;
  assign updEn = in_valid && !stall && !flush && (branch_op != BR_NONE);

  // Only the low PC bits index the table; aliasing is accepted.
  logic unusedPcBits;
  assign unusedPcBits = ^{br_pc[PC_WIDTH-1:IDX_BITS], pred_pc[PC_WIDTH-1:IDX_BITS]};

  branch_predictor_table #(
    .IDX_BITS (IDX_BITS)
  ) uTable (
    .clk         (clk),
    .rst         (rst),
    .updEn       (updEn),
    .updIdx      (br_pc[IDX_BITS-1:0]),
    .updTaken    (taken),
    .lookupIdx   (pred_pc[IDX_BITS-1:0]),
    .lookupTaken (pred_taken)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random traffic
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  branch_op = 3'b000;
  logic [15:0] reg_a = '0;
  logic [15:0] reg_b = '0;
  logic [15:0] br_pc = '0;
  logic        pred_in = 1'b0;
  logic [15:0] pred_pc = '0;
  logic        pred_taken;
  logic        out_valid;
  logic        jmp_true;
  logic        mispredict;
  logic [15:0] result;

  branch_resolve_unit #(
    .WIDTH    (16),
    .IDX_BITS (3),
    .PC_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .branch_op  (branch_op),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .br_pc      (br_pc),
    .pred_in    (pred_in),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .out_valid  (out_valid),
    .jmp_true   (jmp_true),
    .mispredict (mispredict),
    .result     (result)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference state
  int          ctrM [8];
  bit          expV, expJ, expM;
  logic [15:0] expR;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit refTaken(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, ua, ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'({16'h0, a});
    ub = int'({16'h0, b});
    case (op)
      3'd1:    return sa < sb;
      3'd2:    return ua == ub;
      3'd3:    return sa > sb;
      3'd4:    return ua != ub;
      3'd5:    return ua < ub;
      3'd6:    return ua > ub;
      3'd7:    return sa >= sb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit refPred(input logic [15:0] pc);
    return ctrM[pc % 8] >= 2;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) ctrM[i] = 1;
    expV = 0; expJ = 0; expM = 0; expR = '0;
  endtask

  task automatic checkOutputs(input string tag);
    chk({tag, ".out_valid"},  out_valid,  expV);
    chk({tag, ".jmp_true"},   jmp_true,   expJ);
    chk({tag, ".mispredict"}, mispredict, expM);
    chk({tag, ".result"},     result,     expR);
    chk({tag, ".pred_taken"}, pred_taken, refPred(pred_pc));
  endtask

  // Drive one cycle of inputs, check the pre-edge lookup, clock, update model, check.
  task automatic apply(input string tag, input bit iv, input bit st, input bit fl,
                       input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] pc, input bit pin, input logic [15:0] ppc);
    bit tk;
    in_valid = iv; stall = st; flush = fl; branch_op = op;
    reg_a = a; reg_b = b; br_pc = pc; pred_in = pin; pred_pc = ppc;
    #1;
    chk({tag, ".pre_lookup"}, pred_taken, refPred(ppc));
    @(posedge clk);
    tk = refTaken(op, a, b);
    if (!st) begin
      if (fl || !iv) begin
        expV = 0; expJ = 0; expM = 0;
      end else begin
        expV = 1; expJ = tk; expM = tk ^ pin; expR = a - b;
        if (op != 3'd0) begin
          if (tk) ctrM[pc % 8] = (ctrM[pc % 8] == 3) ? 3 : ctrM[pc % 8] + 1;
          else    ctrM[pc % 8] = (ctrM[pc % 8] == 0) ? 0 : ctrM[pc % 8] - 1;
        end
      end
    end
    #1;
    checkOutputs(tag);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutputs("reset");
    rst = 1'b0;

    // Signed less-than with negative operand
    apply("lt_neg", 1, 0, 0, 3'b001, 16'hFFFF, 16'h0001, 16'h0000, 0, 16'h0000);
    // Signed overflow case and unsigned counterpart
    apply("gt_ovf", 1, 0, 0, 3'b011, 16'h7FFF, 16'h8000, 16'h0001, 1, 16'h0001);
    apply("gtu",    1, 0, 0, 3'b110, 16'h7FFF, 16'h8000, 16'h0002, 1, 16'h0002);
    // op none: never taken, mispredict follows pred_in, no table update
    apply("none",   1, 0, 0, 3'b000, 16'h1234, 16'h1234, 16'h0003, 1, 16'h0003);

    // Counter saturation at index 3
    for (int k = 0; k < 4; k++) begin
      apply("sat", 1, 0, 0, 3'b010, 16'd5, 16'd5, 16'h0003, 0, 16'h0003);
    end

    // Flush squashes capture and table update (drive toward not-taken on index 3)
    apply("flush", 1, 0, 1, 3'b100, 16'd7, 16'd7, 16'h0003, 0, 16'h0003);
    apply("idle",  0, 0, 0, 3'b100, 16'd7, 16'd7, 16'h0003, 0, 16'h0003);

    // Capture, then stall with different inputs and flush asserted
    apply("cap",   1, 0, 0, 3'b101, 16'h0002, 16'h0009, 16'h0005, 1, 16'h0005);
    for (int k = 0; k < 3; k++) begin
      apply("stall", 1, 1, 1, 3'b010, 16'h0004, 16'h0004, 16'h0005, 0, 16'h0005);
    end
    apply("unstall", 1, 0, 0, 3'b111, 16'h8000, 16'h0001, 16'h0005, 1, 16'h0005);

    // Saturate every counter, then assert reset asynchronously mid-cycle
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        apply("fill", 1, 0, 0, 3'b100, 16'd1, 16'd2, 16'(i), 0, 16'(i));
      end
    end
    #3;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutputs("async_rst");
    for (int i = 0; i < 8; i++) begin
      pred_pc = 16'(i);
      #1;
      chk("async_rst.pred_idx", pred_taken, 1'b0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    apply("post_rst", 1, 0, 0, 3'b010, 16'd9, 16'd9, 16'h0000, 0, 16'h0000);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a, b, pc, ppc;
      a = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       b = a;
        1:       b = a ^ 16'h8000;
        2:       b = 16'($urandom_range(0, 3)) + 16'h7FFE;
        default: b = 16'($urandom);
      endcase
      pc  = 16'($urandom);
      ppc = ($urandom_range(0, 2) == 0) ? pc : 16'($urandom);
      apply("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, 3'($urandom), a, b, pc, 1'($urandom), ppc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
